sram_fifo_ctrl: RTL and testbench
=================================

# sram_fifo_ctrl

Single-clock FIFO controller that turns the 256x72 dual-port SRAM macro (read port A1/CSB1/OEB1/O1, write port A2/CSB2/WEB2/I2, both ports clocked by `clk`) into a ready/valid queue. It sits directly in front of the macro: it drives the SRAM control/address/data pins and consumes the registered O1 read data. A 2-entry output buffer hides the one-cycle SRAM read latency, so the queue sustains one transfer per cycle.

## Interface
Parameters:
- `WIDTH`, 72, data width; must match the SRAM word.
- `AW`, 8, SRAM address width; `DEPTH` = 2^AW = 256.

Ports:
- `clk`  in  1  clock; also drives SRAM CE1 and CE2 externally.
- `reset`  in  1  asynchronous, active-high reset.
- `enq_valid`  in  1  producer has data.
- `enq_ready`  out  1  controller accepts data.
- `enq_bits`  in  WIDTH  producer data.
- `deq_valid`  out  1  head entry available.
- `deq_ready`  in  1  consumer takes the head.
- `deq_bits`  out  WIDTH  head entry.
- `count`  out  AW+1  total occupancy: SRAM entries, plus in-flight read, plus output buffer entries. Maximum is DEPTH+2.
- `sram_a1`  out  AW  read address.
- `sram_csb1`  out  1  read chip select, active low.
- `sram_oeb1`  out  1  tied to 0.
- `sram_o1`  in  WIDTH  read data, registered in the macro and valid the cycle after the issue.
- `sram_a2`  out  AW  write address.
- `sram_csb2`  out  1  write chip select, active low.
- `sram_web2`  out  1  write enable, active low.
- `sram_i2`  out  WIDTH  write data.

## Operation
- State:
  - `wptr`, `rptr`: AW-bit pointers that wrap modulo DEPTH.
  - `scount`: 0..DEPTH, entries written to SRAM but not yet read-issued.
  - `inflight`: 1 bit, read was issued last cycle.
  - Output buffer: 2 registered entries, with `ocount` 0..2.
- Enqueue:
  - `enq_ready = (scount != DEPTH)`.
  - `enq_fire = enq_valid & enq_ready`.
  - On `enq_fire`: `sram_csb2 = 0`, `sram_web2 = 0`, `sram_a2 = wptr`, `sram_i2 = enq_bits`.
  - At the clock edge, `wptr` increments.
  - When not firing, `csb2 = 1` and `web2 = 1`.
- Read issue:
  - `issue = (scount != 0) & ((ocount + inflight) <= 1 | deq_fire)`.
  - On `issue`: `sram_csb1 = 0`, `sram_a1 = rptr`. At the edge, `rptr` increments and `inflight` is set to 1.
  - When not issuing, `csb1 = 1`. `a1` is don't-care.
- Capture: when `inflight = 1`, `sram_o1` is pushed into the output buffer at the edge, behind any existing entry.
- Dequeue:
  - `deq_valid = (ocount != 0)`.
  - `deq_bits` = oldest buffer entry.
  - `deq_fire = deq_valid & deq_ready` pops the oldest entry.
  - Push and pop in the same cycle are allowed. The buffer never overflows, because `ocount + inflight <= 2` is invariant.
- `scount` next value = `scount + enq_fire - issue`.
  - The simultaneous case, full with enq blocked and issue, is legal.
  - At `scount = DEPTH`, `enq_ready` is 0 even if an issue occurs that cycle. No combinational ready path.
- Same-address hazard:
  - An entry written at edge E is readable only from the cycle after E. `issue` uses the registered `scount`, so no read ever targets a row being written that edge.
- `count = scount + inflight + ocount`.
- Ordering: strict FIFO, with no loss or duplication through pointer wrap from 255 to 0.

## Timing
- Reset (asynchronous): `wptr = rptr = scount = 0`, `inflight = 0`, `ocount = 0`.
  - Outputs during and after reset: `deq_valid = 0`, `count = 0`, `enq_ready = 1`, `sram_csb1 = 1`, `sram_oeb1 = 0`.
  - `sram_csb2` and `sram_web2` equal `~enq_valid`.
- Reset mid-operation:
  - All queued data is discarded. SRAM contents are untouched but unreachable.
  - An O1 value pending at deassertion is ignored, because `inflight` was cleared.
- Latency: an enq firing in cycle N (empty queue) gives the SRAM write at the end of N.
  - Issue happens in N+1, capture at the end of N+2.
  - `deq_valid = 1` in cycle N+3 with that data.
- Throughput: with `enq_valid` and `deq_ready` held high, one enq and one deq every cycle in steady state.
- Every handshake output except `enq_ready` is a function of registers only. `enq_ready` is also registered-only (it depends on `scount`).

## Test plan
- Reset then idle:
  - Expect `deq_valid = 0`, `count = 0`, `enq_ready = 1`, `csb1 = 1`.
  - Assert reset mid-stream with 10 entries queued; expect `count = 0` and `deq_valid = 0` within the reset cycle.
- Single word:
  - Enq `72'h0123456789ABCDEF01` in cycle 0.
  - Expect `deq_valid` first high in cycle 3 with that value, and `count` going 0→1.
- Fill, with `deq_ready = 0`:
  - Enq incrementing values until `enq_ready` drops.
  - Expect 258 accepted, `count = 258`, `scount = 256`, `enq_ready = 0`.
  - Then drain; expect values 0..257 in order.
- Full-rate streaming:
  - Hold both valid and ready for 1000 cycles with incrementing data, crossing pointer wrap 3 times.
  - Expect one deq per cycle after the 3-cycle fill and exact in-order data.
- Random backpressure:
  - Drive random `enq_valid` and `deq_ready` (50%) for 10k cycles against a scoreboard.
  - Expect no loss or duplication, `count` matching the model, and `csb1` never low when `scount = 0`.
- Read/write collision:
  - With `scount = 0`, enq in cycle N.
  - Expect `csb1 = 1` in cycle N and `csb1 = 0` with `a1 = a2(N)` in N+1.

Source files
------------

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl
//   Single-clock ready/valid FIFO built around a 2^AW x WIDTH dual-port SRAM
//   macro (registered read port 1, write port 2). The SRAM read latency is
//   hidden by a 2-entry output buffer, so one enqueue and one dequeue can
//   complete every cycle.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   enq_valid/ready/bits  producer handshake and data
//   deq_valid/ready/bits  consumer handshake and head data
//   count                 total occupancy (SRAM + in-flight read + buffer)
//   sram_a1/csb1/oeb1     SRAM read port address / select (low) / output enable
//   sram_o1               SRAM registered read data
//   sram_a2/csb2/web2/i2  SRAM write port address / select / write enable / data
module sram_fifo_ctrl #(
   parameter int unsigned WIDTH = 72,
   parameter int unsigned AW    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enq_valid,
   output logic             enq_ready,
   input  logic [WIDTH-1:0] enq_bits,
   output logic             deq_valid,
   input  logic             deq_ready,
   output logic [WIDTH-1:0] deq_bits,
   output logic [AW:0]      count,
   output logic [AW-1:0]    sram_a1,
   output logic             sram_csb1,
   output logic             sram_oeb1,
   input  logic [WIDTH-1:0] sram_o1,
   output logic [AW-1:0]    sram_a2,
   output logic             sram_csb2,
   output logic             sram_web2,
   output logic [WIDTH-1:0] sram_i2
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      scount_q, scount_d;
   logic             inflight_q, inflight_d;
   logic [1:0]       ocount_q, ocount_d;
   logic [WIDTH-1:0] buf0_q, buf0_d;   // head of the output buffer
   logic [WIDTH-1:0] buf1_q, buf1_d;

   logic       enq_fire;
   logic       deq_fire;
   logic       issue;
   logic [2:0] pending;

   assign enq_ready = (scount_q != (AW+1)'(DEPTH));
   assign enq_fire  = enq_valid & enq_ready;
   assign deq_valid = (ocount_q != 2'd0);
   assign deq_fire  = deq_valid & deq_ready;
   assign deq_bits  = buf0_q;

   // Reads already owed to the buffer; a new read may issue only if the
   // buffer is guaranteed a free slot when its data returns.
   assign pending = {1'b0, ocount_q} + {2'b00, inflight_q};
   assign issue   = (scount_q != '0) && ((pending <= 3'd1) || deq_fire);

   assign count = scount_q + (AW+1)'(inflight_q) + (AW+1)'(ocount_q);

   // SRAM pins
   assign sram_a1   = rptr_q;
   assign sram_csb1 = ~issue;
   assign sram_oeb1 = 1'b0;
   assign sram_a2   = wptr_q;
   assign sram_csb2 = ~enq_fire;
   assign sram_web2 = ~enq_fire;
   assign sram_i2   = enq_bits;

   always_comb begin
      wptr_d     = wptr_q + AW'(enq_fire);
      rptr_d     = rptr_q + AW'(issue);
      scount_d   = scount_q + (AW+1)'(enq_fire) - (AW+1)'(issue);
      inflight_d = issue;
   end

   // Output buffer: buf0 is always the oldest entry. A push lands in the
   // first free slot after any pop has shifted buf1 forward.
   always_comb begin
      buf0_d   = buf0_q;
      buf1_d   = buf1_q;
      ocount_d = ocount_q;
      unique case ({inflight_q, deq_fire})
         2'b10: begin
            if (ocount_q == 2'd0) buf0_d = sram_o1;
            else                  buf1_d = sram_o1;
            ocount_d = ocount_q + 2'd1;
         end
         2'b01: begin
            buf0_d   = buf1_q;
            ocount_d = ocount_q - 2'd1;
         end
         2'b11: begin
            if (ocount_q == 2'd1) begin
               buf0_d = sram_o1;
            end else begin
               buf0_d = buf1_q;
               buf1_d = sram_o1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         scount_q   <= '0;
         inflight_q <= 1'b0;
         ocount_q   <= '0;
         buf0_q     <= '0;
         buf1_q     <= '0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         scount_q   <= scount_d;
         inflight_q <= inflight_d;
         ocount_q   <= ocount_d;
         buf0_q     <= buf0_d;
         buf1_q     <= buf1_d;
      end
   end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl
//   Randomised and directed bench for sram_fifo_ctrl. Includes a behavioural
//   model of the 256x72 SRAM macro and a queue-based reference of the FIFO.
module tb_sram_fifo_ctrl;

   localparam int unsigned WIDTH = 72;
   localparam int unsigned AW    = 8;
   localparam int          DEPTH = 256;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             enq_valid = 1'b0;
   logic             enq_ready;
   logic [WIDTH-1:0] enq_bits = '0;
   logic             deq_valid;
   logic             deq_ready = 1'b0;
   logic [WIDTH-1:0] deq_bits;
   logic [AW:0]      count;
   logic [AW-1:0]    sram_a1;
   logic             sram_csb1;
   logic             sram_oeb1;
   logic [WIDTH-1:0] sram_o1;
   logic [AW-1:0]    sram_a2;
   logic             sram_csb2;
   logic             sram_web2;
   logic [WIDTH-1:0] sram_i2;

   sram_fifo_ctrl #(.WIDTH(WIDTH), .AW(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .enq_valid (enq_valid),
      .enq_ready (enq_ready),
      .enq_bits  (enq_bits),
      .deq_valid (deq_valid),
      .deq_ready (deq_ready),
      .deq_bits  (deq_bits),
      .count     (count),
      .sram_a1   (sram_a1),
      .sram_csb1 (sram_csb1),
      .sram_oeb1 (sram_oeb1),
      .sram_o1   (sram_o1),
      .sram_a2   (sram_a2),
      .sram_csb2 (sram_csb2),
      .sram_web2 (sram_web2),
      .sram_i2   (sram_i2)
   );

   always #5 clk = ~clk;

   // SRAM macro: registered read, synchronous write.
   logic [WIDTH-1:0] mem [DEPTH];
   initial sram_o1 = '0;
   always @(posedge clk) begin
      if (!sram_csb2 && !sram_web2) mem[sram_a2] <= sram_i2;
      if (!sram_csb1) sram_o1 <= mem[sram_a1];
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [WIDTH-1:0] got,
                        input logic [WIDTH-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: q holds every accepted item in order; ms/mi/mo are the
   // occupancy of SRAM, the read stage and the output buffer.
   logic [WIDTH-1:0] q[$];
   int ms, mi, mo, mw, mr, ndeq;
   logic             last_dv, last_ready, last_csb1;
   logic [AW-1:0]    last_a1, last_a2;
   logic [AW:0]      last_cnt;
   logic [WIDTH-1:0] last_bits;

   task automatic model_reset();
      q.delete();
      ms = 0; mi = 0; mo = 0; mw = 0; mr = 0;
   endtask

   task automatic cycle(input logic ev, input logic dr, input logic [WIDTH-1:0] d);
      logic e_ready, e_dv, efire, dfire, iss;
      int   nmo;
      @(negedge clk);
      enq_valid = ev; deq_ready = dr; enq_bits = d;
      #1;
      e_ready = (ms != DEPTH);
      e_dv    = (mo != 0);
      efire   = ev && e_ready;
      dfire   = dr && e_dv;
      iss     = (ms != 0) && ((mo + mi) <= 1 || dfire);
      last_dv = deq_valid; last_ready = enq_ready; last_cnt = count;
      last_csb1 = sram_csb1; last_a1 = sram_a1; last_a2 = sram_a2;
      last_bits = deq_bits;
      check("enq_ready", WIDTH'(enq_ready), WIDTH'(e_ready));
      check("deq_valid", WIDTH'(deq_valid), WIDTH'(e_dv));
      check("count", WIDTH'(count), WIDTH'(ms + mi + mo));
      check("csb1", WIDTH'(sram_csb1), WIDTH'(!iss));
      check("csb2", WIDTH'(sram_csb2), WIDTH'(!efire));
      check("web2", WIDTH'(sram_web2), WIDTH'(!efire));
      if (e_dv) check("deq_bits", deq_bits, q[0]);
      if (iss) check("a1", WIDTH'(sram_a1), WIDTH'(mr % DEPTH));
      if (efire) begin
         check("a2", WIDTH'(sram_a2), WIDTH'(mw % DEPTH));
         check("i2", sram_i2, d);
      end
      @(posedge clk);
      if (efire) begin q.push_back(d); mw++; ms++; end
      if (iss) begin ms--; mr++; end
      nmo = mo + mi - (dfire ? 1 : 0);
      mi  = iss ? 1 : 0;
      mo  = nmo;
      if (dfire) begin void'(q.pop_front()); ndeq++; end
   endtask

   task automatic do_reset(input logic ev);
      @(negedge clk);
      reset = 1'b1; enq_valid = ev; deq_ready = 1'b0;
      #1;
      check("rst_deq_valid", WIDTH'(deq_valid), '0);
      check("rst_count", WIDTH'(count), '0);
      check("rst_enq_ready", WIDTH'(enq_ready), WIDTH'(1));
      check("rst_csb1", WIDTH'(sram_csb1), WIDTH'(1));
      check("rst_oeb1", WIDTH'(sram_oeb1), '0);
      check("rst_csb2", WIDTH'(sram_csb2), WIDTH'(!ev));
      check("rst_web2", WIDTH'(sram_web2), WIDTH'(!ev));
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0; enq_valid = 1'b0;
      model_reset();
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0) && (n < 600)) begin
         cycle(1'b0, 1'b1, '0);
         n++;
      end
      check("drain_done", WIDTH'(q.size()), '0);
   endtask

   initial begin
      logic [WIDTH-1:0] d;
      logic [95:0]      r;
      logic [AW-1:0]    saved_a2;
      int               acc, n;

      model_reset();
      ndeq = 0;
      // Reset then idle
      do_reset(1'b0);
      do_reset(1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, '0);

      // Single word latency
      d = 72'h0123456789ABCDEF01;
      for (int k = 0; k < 5; k++) begin
         cycle(k == 0, 1'b0, d);
         check("lat_dv", WIDTH'(last_dv), WIDTH'(k >= 3));
         check("lat_cnt", WIDTH'(last_cnt), WIDTH'((k == 0) ? 0 : 1));
         if (k == 3) check("lat_bits", last_bits, 72'h0123456789ABCDEF01);
      end
      drain();

      // Fill with deq_ready low
      acc = 0; n = 0;
      do begin
         cycle(1'b1, 1'b0, WIDTH'(acc));
         if (last_ready) acc++;
         n++;
      end while (last_ready && n < 400);
      check("fill_accepted", WIDTH'(acc), WIDTH'(258));
      check("fill_count", WIDTH'(last_cnt), WIDTH'(258));
      check("fill_ready", WIDTH'(last_ready), '0);
      ndeq = 0;
      drain();
      check("fill_drained", WIDTH'(ndeq), WIDTH'(258));

      // Full-rate streaming
      ndeq = 0;
      for (int i = 0; i < 1000; i++) cycle(1'b1, 1'b1, WIDTH'(i + 1000));
      check("stream_deqs", WIDTH'(ndeq), WIDTH'(997));
      drain();

      // Read/write collision on empty queue
      do_reset(1'b0);
      cycle(1'b1, 1'b0, WIDTH'(72'h55));
      saved_a2 = last_a2;
      check("coll_csb1_n", WIDTH'(last_csb1), WIDTH'(1));
      cycle(1'b0, 1'b0, '0);
      check("coll_csb1_n1", WIDTH'(last_csb1), '0);
      check("coll_a1", WIDTH'(last_a1), WIDTH'(saved_a2));
      drain();

      // Random backpressure
      for (int i = 0; i < 10000; i++) begin
         r = {$urandom(), $urandom(), $urandom()};
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r[WIDTH-1:0]);
      end
      drain();

      // Reset mid-stream with 10 entries queued and a read in flight
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, WIDTH'(i + 7));
      check("pre_rst_count", WIDTH'(last_cnt), WIDTH'(9));
      cycle(1'b0, 1'b1, '0);
      do_reset(1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, '0);
      check("post_rst_dv", WIDTH'(last_dv), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
